// File: rtl/rst_clk_ctrl_pkg.sv
// rst_clk_ctrl_pkg: clock source encoding and default timing constants for reset_clk_ctrl
package rst_clk_ctrl_pkg;
  typedef enum logic [1:0] {SRC_BASE, SRC_PLL, SRC_ROSC} src_e;
  localparam int POR_CYCLES_DEF = 16;
  localparam int PLL_LOCK_CYCLES_DEF = 64;
  localparam int RST_EDGES_DEF = 4;
endpackage

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: counts 0..period-1 and ticks on the last count; in clk_ref, restart (sync clear), period[2:0]; out tick
module clk_tick_gen (
  input  logic       clk_ref,
  input  logic       restart,
  input  logic [2:0] period,
  output logic       tick
);
  logic [2:0] cnt;
  assign tick = cnt == period - 3'd1;
  always_ff @(posedge clk_ref)
    cnt <= (restart || tick) ? 3'd0 : cnt + 3'd1;
endmodule

// File: rtl/reset_clk_ctrl.sv
// reset_clk_ctrl: glitch-free clock root and POR/system reset sequencer; in clk_ref, xrst, pll_en, pll_trim, sel_8mhz, sel_pll, sel_rosc, clk_div; out clk, rst_n, por_n; PLL path only when RST_CLK_PLL_EN is defined
module reset_clk_ctrl
  import rst_clk_ctrl_pkg::*;
#(
  parameter int POR_CYCLES      = POR_CYCLES_DEF,
  parameter int PLL_LOCK_CYCLES = PLL_LOCK_CYCLES_DEF,
  parameter int RST_EDGES       = RST_EDGES_DEF
) (
  input  logic       clk_ref,
  input  logic       xrst,
  input  logic       pll_en,
  input  logic [1:0] pll_trim,
  input  logic       sel_8mhz,
  input  logic       sel_pll,
  input  logic [1:0] sel_rosc,
  input  logic [1:0] clk_div,
  output logic       clk,
  output logic       rst_n,
  output logic       por_n
);
  localparam int PW = $clog2(POR_CYCLES + 1);
  localparam int EW = $clog2(RST_EDGES + 1);
  src_e act_src, nxt_src;
  logic [1:0] act_rosc, act_div;
  logic [2:0] div_cnt, div_max;
  logic [PW-1:0] por_cnt;
  logic [EW-1:0] edge_cnt;
  logic tick, wrap, fall, rosc_tick, pll_tick;
  clk_tick_gen u_rosc (
    .clk_ref (clk_ref),
    .restart (xrst || fall),
    .period  (3'd1 + {1'b0, act_rosc}),
    .tick    (rosc_tick)
  );
`ifdef RST_CLK_PLL_EN
  localparam int LW = $clog2(PLL_LOCK_CYCLES + 1);
  logic [LW-1:0] lock_cnt;
  logic [1:0] act_trim;
  logic locked;
  assign locked = lock_cnt == LW'(PLL_LOCK_CYCLES);
  assign nxt_src = sel_8mhz ? SRC_BASE : sel_pll ? (locked ? SRC_PLL : SRC_BASE) : SRC_ROSC;
  always_ff @(posedge clk_ref)
    if (xrst) begin
      lock_cnt <= '0;
      act_trim <= '0;
    end else begin
      lock_cnt <= !pll_en ? '0 : locked ? lock_cnt : lock_cnt + 1'b1;
      if (fall) act_trim <= pll_trim;
    end
  clk_tick_gen u_pll (
    .clk_ref (clk_ref),
    .restart (xrst || fall),
    .period  (3'd2 + {1'b0, act_trim}),
    .tick    (pll_tick)
  );
`else
  logic unused_pll;
  assign unused_pll = ^{pll_en, sel_pll, pll_trim};
  assign nxt_src = sel_8mhz ? SRC_BASE : SRC_ROSC;
  assign pll_tick = 1'b0;
`endif
  assign div_max = 3'((4'd1 << act_div) - 4'd1);
  assign tick = act_src == SRC_BASE ? 1'b1 : act_src == SRC_PLL ? pll_tick : rosc_tick;
  assign wrap = tick && div_cnt == div_max;
  assign fall = wrap && clk;
  always_ff @(posedge clk_ref)
    if (xrst) begin
      clk      <= 1'b0;
      por_n    <= 1'b0;
      rst_n    <= 1'b0;
      por_cnt  <= '0;
      edge_cnt <= '0;
      div_cnt  <= '0;
      act_src  <= SRC_BASE;
      act_rosc <= '0;
      act_div  <= '0;
    end else begin
      if (!por_n) begin
        por_cnt <= por_cnt + 1'b1;
        por_n   <= por_cnt == PW'(POR_CYCLES - 1);
      end
      if (tick) div_cnt <= wrap ? 3'd0 : div_cnt + 3'd1;
      if (wrap) clk <= !clk;
      if (fall) begin
        act_src  <= nxt_src;
        act_rosc <= sel_rosc;
        act_div  <= clk_div;
      end
      if (fall && por_n && !rst_n) begin
        edge_cnt <= edge_cnt + 1'b1;
        rst_n    <= edge_cnt == EW'(RST_EDGES - 1);
      end
    end
endmodule

// File: tb/tb_reset_clk_ctrl.sv
// tb_reset_clk_ctrl: table-driven scoreboard bench for reset_clk_ctrl clock periods and reset sequencing
module tb_reset_clk_ctrl;
  typedef struct {
    logic       s8;
    logic       sp;
    logic       pe;
    logic [1:0] trim;
    logic [1:0] rosc;
    logic [1:0] div;
    int         per;
  } vec_t;
  logic clk_ref = 1'b0;
  logic xrst, pll_en, sel_8mhz, sel_pll;
  logic [1:0] pll_trim, sel_rosc, clk_div;
  logic clk, rst_n, por_n;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int sb[$];
  vec_t tbl[8];
  reset_clk_ctrl dut (
    .clk_ref  (clk_ref),
    .xrst     (xrst),
    .pll_en   (pll_en),
    .pll_trim (pll_trim),
    .sel_8mhz (sel_8mhz),
    .sel_pll  (sel_pll),
    .sel_rosc (sel_rosc),
    .clk_div  (clk_div),
    .clk      (clk),
    .rst_n    (rst_n),
    .por_n    (por_n)
  );
  always #5 clk_ref = ~clk_ref;
  always @(posedge clk_ref) cyc <= cyc + 1;
  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic set_in(input logic s8, input logic sp, input logic pe,
                        input logic [1:0] trim, input logic [1:0] rosc, input logic [1:0] div);
    sel_8mhz = s8;
    sel_pll  = sp;
    pll_en   = pe;
    pll_trim = trim;
    sel_rosc = rosc;
    clk_div  = div;
  endtask
  task automatic wait_edge(input logic lvl, output int t);
    logic p;
    p = clk;
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk_ref);
      #1;
      if (p != lvl && clk == lvl) begin
        t = cyc;
        break;
      end
      p = clk;
    end
  endtask
  task automatic run_vec(input string nm, input int exp);
    int t0, t1, t2, e;
    sb.push_back(exp);
    wait_edge(1'b0, t0);
    wait_edge(1'b1, t1);
    wait_edge(1'b0, t2);
    e = sb.pop_front();
    check({nm, " period"}, t2 - t0, e);
    check({nm, " low"}, t1 - t0, e / 2);
    check({nm, " high"}, t2 - t1, e / 2);
  endtask
  task automatic por_seq(input string nm);
    int k, f;
    logic p;
    xrst = 1'b0;
    k = 0;
    do begin
      @(posedge clk_ref);
      #1;
      k++;
    end while (!por_n && k < 100);
    check({nm, " por_cycles"}, k, 16);
    check({nm, " rst_n_at_por"}, int'(rst_n), 0);
    f = 0;
    p = clk;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_ref);
      #1;
      if (p && !clk) f++;
      p = clk;
      if (rst_n) break;
    end
    check({nm, " rst_falls"}, f, 4);
    check({nm, " rst_n_high"}, int'(rst_n), 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 8};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 2'd0, 2'd3, 2'd1, 4};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd3, 64};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 4};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, 12};
`ifdef RST_CLK_PLL_EN
    tbl[7] = '{1'b0, 1'b1, 1'b0, 2'd3, 2'd1, 2'd0, 2};
`else
    tbl[7] = '{1'b0, 1'b1, 1'b0, 2'd3, 2'd1, 2'd0, 4};
`endif
    xrst = 1'b1;
    set_in(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    repeat (5) @(posedge clk_ref);
    #1;
    check("reset clk", int'(clk), 0);
    check("reset por_n", int'(por_n), 0);
    check("reset rst_n", int'(rst_n), 0);
    por_seq("power_on");
    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].s8, tbl[i].sp, tbl[i].pe, tbl[i].trim, tbl[i].rosc, tbl[i].div);
      run_vec($sformatf("vec%0d", i), tbl[i].per);
    end
`ifdef RST_CLK_PLL_EN
    set_in(1'b0, 1'b1, 1'b1, 2'd2, 2'd0, 2'd1);
    run_vec("pll_unlocked", 4);
    repeat (70) @(posedge clk_ref);
    #1;
    run_vec("pll_locked", 16);
    set_in(1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 2'd1);
    run_vec("pll_drop", 4);
`else
    set_in(1'b0, 1'b1, 1'b1, 2'd3, 2'd1, 2'd0);
    repeat (70) @(posedge clk_ref);
    #1;
    run_vec("no_pll_rosc", 4);
`endif
    begin
      int t;
      set_in(1'b0, 1'b0, 1'b0, 2'd0, 2'd3, 2'd3);
      run_vec("slow_rosc", 64);
      wait_edge(1'b1, t);
      check("midrun clk_high_before", int'(clk), 1);
      xrst = 1'b1;
      @(posedge clk_ref);
      #1;
      check("midrun clk", int'(clk), 0);
      check("midrun por_n", int'(por_n), 0);
      check("midrun rst_n", int'(rst_n), 0);
      set_in(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
      repeat (2) @(posedge clk_ref);
      #1;
      por_seq("repor");
      run_vec("after_repor", 2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
